// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one 8-bit SPI master engine among NREQ requesters.
// Owns the slave selects and engine start; sequences CS setup/hold and a per-byte watchdog.
module spi_bus_arbiter #(
    parameter int NREQ     = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   last,
    input  logic [8*NREQ-1:0] tx_data,
    output logic [NREQ-1:0]   gnt,
    output logic              byte_ack,
    output logic [7:0]        rx_data,
    output logic              err,
    output logic              eng_start,
    output logic [7:0]        eng_tx,
    input  logic              eng_done,
    input  logic [7:0]        eng_rx,
    output logic [NREQ-1:0]   ss_n
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LAUNCH,
        WAIT,
        ACK,
        HOLD
    } state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   ptr, ptr_nx;
    logic [IW-1:0]   g, g_nx;
    logic [IW-1:0]   win;
    logic [IW:0]     sum;
    logic            found;
    logic [7:0]      cnt, cnt_nx;
    logic [7:0]      wd, wd_nx;
    logic [7:0]      tx_q, tx_nx;
    logic [7:0]      rx_nx;
    logic            last_q, last_nx;
    logic [NREQ-1:0] gnt_nx;
    logic [7:0]      tx_sel;

    assign tx_sel = tx_data[{g, 3'b000} +: 8];
    assign ss_n   = ~gnt;

    // First requester at or above the pointer, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            if (!found && req[sum[IW-1:0]]) begin
                found = 1'b1;
                win   = sum[IW-1:0];
            end
        end
    end

    always_comb begin
        state_nx  = state;
        ptr_nx    = ptr;
        g_nx      = g;
        cnt_nx    = cnt;
        wd_nx     = wd;
        tx_nx     = tx_q;
        rx_nx     = rx_data;
        last_nx   = last_q;
        gnt_nx    = gnt;
        eng_start = 1'b0;
        eng_tx    = tx_q;
        byte_ack  = 1'b0;
        err       = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    g_nx        = win;
                    gnt_nx      = '0;
                    gnt_nx[win] = 1'b1;
                    cnt_nx      = '0;
                    state_nx    = SETUP;
                end
            end
            SETUP: begin
                if (cnt == 8'(CS_SETUP-1)) begin
                    state_nx = LAUNCH;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            LAUNCH: begin
                if (!req[g]) begin
                    cnt_nx   = '0;
                    state_nx = HOLD;
                end else begin
                    eng_start = 1'b1;
                    eng_tx    = tx_sel;
                    tx_nx     = tx_sel;
                    last_nx   = last[g];
                    wd_nx     = '0;
                    state_nx  = WAIT;
                end
            end
            WAIT: begin
                if (eng_done) begin
                    rx_nx    = eng_rx;
                    state_nx = ACK;
                end else if (wd == 8'(TIMEOUT-1)) begin
                    err      = 1'b1;
                    cnt_nx   = '0;
                    state_nx = HOLD;
                end else begin
                    wd_nx = wd + 8'd1;
                end
            end
            ACK: begin
                byte_ack = 1'b1;
                if (last_q) begin
                    cnt_nx   = '0;
                    state_nx = HOLD;
                end else begin
                    state_nx = LAUNCH;
                end
            end
            HOLD: begin
                if (cnt == 8'(CS_HOLD-1)) begin
                    gnt_nx   = '0;
                    ptr_nx   = (g == IW'(NREQ-1)) ? '0 : g + 1'b1;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            g       <= '0;
            cnt     <= '0;
            wd      <= '0;
            tx_q    <= '0;
            rx_data <= '0;
            last_q  <= 1'b0;
            gnt     <= '0;
        end else begin
            state   <= state_nx;
            ptr     <= ptr_nx;
            g       <= g_nx;
            cnt     <= cnt_nx;
            wd      <= wd_nx;
            tx_q    <= tx_nx;
            rx_data <= rx_nx;
            last_q  <= last_nx;
            gnt     <= gnt_nx;
        end
    end

endmodule
